// File: rtl/ex_mem_pipe_stage.sv
// rtl/ex_mem_pipe_stage.sv - elastic EX->MEM pipeline register; PIPE_SKID_EN selects the two-entry skid buffer
// State updates on the falling clock edge; outputs come straight from the main register.
module ex_mem_pipe_stage #(
  parameter int XLEN   = 32,
  parameter int RD_W   = 5,
  parameter int RSRC_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ValidE,
  output logic              ReadyE,
  input  logic              RegWriteE,
  input  logic [RSRC_W-1:0] ResultSrcE,
  input  logic              MemWriteE,
  input  logic [XLEN-1:0]   ALUResultE,
  input  logic [XLEN-1:0]   WriteDataE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [RD_W-1:0]   RdE,
  input  logic              FlushE,
  output logic              ValidM,
  input  logic              ReadyM,
  output logic              RegWriteM,
  output logic [RSRC_W-1:0] ResultSrcM,
  output logic              MemWriteM,
  output logic [XLEN-1:0]   ALUResultM,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [RD_W-1:0]   RdM,
  output logic [XLEN-1:0]   PCPlus4M,
  output logic              FwdRegWriteM,
  output logic [RD_W-1:0]   FwdRdM
);

  localparam int BW = 2 + RSRC_W + 3 * XLEN + RD_W;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t        state;
  logic [BW-1:0] in_bundle;
  logic [BW-1:0] main_q;
  logic          valid_q;
  logic          in_xfer;
  logic          out_xfer;
  logic          reg_write_q;
  logic          mem_write_q;

  assign in_bundle = {RegWriteE, ResultSrcE, MemWriteE, ALUResultE, WriteDataE, RdE, PCPlus4E};
  assign in_xfer   = ValidE & ReadyE;
  assign out_xfer  = valid_q & ReadyM;

`ifdef PIPE_SKID_EN
  logic [BW-1:0] skid_q;
  logic          ready_q;

  // ready_q mirrors "skid empty" so ReadyE never sees ReadyM combinationally
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (FlushE) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (in_xfer) begin
          main_q  <= in_bundle;
          valid_q <= 1'b1;
          state   <= ONE;
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_bundle;
          end else if (in_xfer) begin
            skid_q  <= in_bundle;
            ready_q <= 1'b0;
            state   <= TWO;
          end else if (out_xfer) begin
            valid_q <= 1'b0;
            state   <= EMPTY;
          end
        end
        TWO: if (out_xfer) begin
          main_q  <= skid_q;
          ready_q <= 1'b1;
          state   <= ONE;
        end
        default: begin
          state   <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ReadyE = ready_q;
`else
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      main_q  <= '0;
    end else if (FlushE) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (in_xfer) begin
          main_q  <= in_bundle;
          valid_q <= 1'b1;
          state   <= ONE;
        end
        ONE: begin
          // accepting while full implies MEM is draining this same edge
          if (in_xfer) begin
            main_q <= in_bundle;
          end else if (out_xfer) begin
            valid_q <= 1'b0;
            state   <= EMPTY;
          end
        end
        default: begin
          state   <= EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ReadyE = ReadyM | ~valid_q;
`endif

  assign {reg_write_q, ResultSrcM, mem_write_q, ALUResultM, WriteDataM, RdM, PCPlus4M} = main_q;

  assign ValidM       = valid_q;
  assign RegWriteM    = reg_write_q & valid_q;
  assign MemWriteM    = mem_write_q & valid_q;
  assign FwdRegWriteM = reg_write_q & valid_q;
  assign FwdRdM       = FwdRegWriteM ? RdM : '0;

endmodule

// File: doc/ex_mem_pipe_stage.md
# ex_mem_pipe_stage

Parametrised, elastic EX→MEM pipeline stage register for the RISC-V core. It carries the execute-stage result bundle (write-back controls, ALU result, store data, destination register, PC+4) into the memory stage under a valid/ready handshake. It adds stall back-pressure, flush-to-bubble and qualified forwarding taps. An optional two-entry skid buffer registers the ready path. It replaces the fixed-width, always-loading EX/MEM register.

## Interface
Parameters:
- XLEN, 32, width of ALU result, store data and PC+4.
- RD_W, 5, destination register index width.
- RSRC_W, 2, result-source select width.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state updates on the falling edge.
- rst_n  in  1  asynchronous active-low reset.
- ValidE  in  1  EX stage presents a valid bundle.
- ReadyE  out  1  stage can accept a bundle this cycle.
- RegWriteE, ResultSrcE, MemWriteE  in  1/RSRC_W/1  EX control fields.
- ALUResultE, WriteDataE, PCPlus4E  in  XLEN each  EX data fields.
- RdE  in  RD_W  EX destination register.
- FlushE  in  1  discard all held bundles and any bundle offered this cycle.
- ValidM  out  1  MEM-side bundle valid.
- ReadyM  in  1  MEM stage consumes the bundle this cycle.
- RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM, PCPlus4M  out  matching widths  MEM-side fields.
- FwdRegWriteM  out  1  RegWriteM & ValidM, for hazard/forwarding unit.
- FwdRdM  out  RD_W  RdM when FwdRegWriteM, else 0.

## Operation
- Transfer in: ValidE & ReadyE at a clock edge. Transfer out: ValidM & ReadyM at a clock edge.
- Main register holds the bundle presented to MEM. The skid register is used only with PIPE_SKID_EN.
- States (PIPE_SKID_EN): EMPTY (no valid entries), ONE (main valid), TWO (main and skid valid).
  - EMPTY: transfer in → ONE.
  - ONE: in only → TWO (new bundle to skid). Out only → EMPTY. In and out → ONE (new bundle to main).
  - TWO: ReadyE=0. Out → ONE (skid moves to main, skid cleared).
- ReadyE = !skid_valid: a register output, with no combinational path from ReadyM.
- FlushE: on the next edge both valid bits clear and the offered bundle is dropped. The state becomes EMPTY.
- FlushE has priority over every simultaneous transfer. A transfer out in the flush cycle still counts as consumed by MEM.
- Bubble safety: RegWriteM, MemWriteM and FwdRegWriteM are forced to 0 whenever ValidM=0.
- Other data outputs hold their last value when invalid and are don't-care.
- Ordering is strictly FIFO: no bundle is lost, duplicated or reordered without FlushE.
- Reset mid-operation clears all valid bits immediately, regardless of clk.

## Timing
- Reset values:
  - ValidM=0, ReadyE=1.
  - RegWriteM=0, MemWriteM=0, FwdRegWriteM=0, FwdRdM=0.
  - ResultSrcM, ALUResultM, WriteDataM, PCPlus4M and RdM all 0.
- Latency is one clock: a bundle accepted at edge n is visible on the M outputs after edge n, with ValidM=1.
- Throughput is one bundle per cycle while ReadyM=1.
- With ReadyM held low, the stage absorbs at most two bundles (PIPE_SKID_EN) or one (without it). ReadyE then falls after the edge at which the stage fills.
- M outputs are driven directly from the main register, with no logic except the valid gating on the write enables.

## Configuration
- PIPE_SKID_EN defined: two-entry skid buffer as above. ReadyE is registered, so the ReadyM→ReadyE timing path is broken.
- PIPE_SKID_EN undefined: single main register with ReadyE = ReadyM | !ValidM, a combinational path. States reduce to EMPTY/ONE.
  - Accept in ONE is allowed only when ReadyM=1, in the same cycle as the transfer out.
  - Flush and bubble rules are unchanged.

## Test plan
- Reset: assert rst_n=0 between edges → ValidM=0, ReadyE=1, RegWriteM=0, FwdRdM=0 immediately; all M data outputs=0.
- Streaming: ReadyM=1, ten back-to-back bundles with ALUResultE=0x100+i, RdE=i → ALUResultM=0x100+i one edge after each accept, ValidM high continuously, no gaps.
- Back-pressure (skid): ReadyM=0, offer A (RdE=3) then B (RdE=4) → ReadyE=0 after second accept, C held at input. Raise ReadyM → A, B, C appear in order on RdM.
- Flush: stage in TWO, assert FlushE with a valid offer D on the same edge → ValidM=0, MemWriteM=0 next cycle. A later bundle E appears and D never does.
- Forwarding taps: accept bundle RegWriteE=1, RdE=7, then bubble → FwdRdM=7, FwdRegWriteM=1 for one cycle, then FwdRdM=0 with FwdRegWriteM=0.
- No-skid build (PIPE_SKID_EN undefined): ValidM=1, ReadyM=0 → ReadyE=0 in the same cycle. ReadyM=1 → ReadyE=1 combinationally, and the new bundle replaces the old at the edge.
